multicycle_exec_unit: RTL and testbench
=======================================

// Module: multicycle_exec_unit
// PURPOSE
//  Responder side of the one-hot stage controller handshake (IFetch/IDecode/Exec/Mem/WB + Instdone).
//  Watches the one-hot stage strobes, runs the multicycle ALU operation while Exec is held,
//  and drives Instdone to release the controller from Exec. Implements ADD, SUB, MUL (iterative) and
//  DIVU (iterative). Sits between the stage controller and the register-file write-back path.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2); MUL/DIVU iterate WIDTH cycles
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  ifetch       in   1      stage strobe from controller
//  idecode      in   1      stage strobe
//  exec         in   1      stage strobe; held high by controller until instdone sampled high
//  mem          in   1      stage strobe
//  wb           in   1      stage strobe
//  op           in   2      00 ADD, 01 SUB, 10 MUL (unsigned), 11 DIVU; sampled at start only
//  src_a        in   WIDTH  operand A / dividend; sampled at start only
//  src_b        in   WIDTH  operand B / divisor; sampled at start only
//  instdone     out  1      high while state==DONE (decoded from state register, glitch-free)
//  busy         out  1      high while state==BUSY
//  result_lo    out  WIDTH  sum/diff, product[W-1:0], or quotient
//  result_hi    out  WIDTH  0 for ADD/SUB, product[2W-1:W], or remainder
//  result_valid out  1      set on entry to DONE; cleared at next start
//  div_by_zero  out  1      set at start of DIVU with src_b==0; cleared at next start
//  proto_err    out  1      sticky; cleared only by rst_n
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; operand/accumulator/counter registers 0.
//  States: IDLE, BUSY, DONE (2-bit binary encoding).
//  Start: in IDLE with exec=1 (cycle E0) -> latch op/src_a/src_b; clear result_valid/div_by_zero.
//   ADD/SUB, or DIVU with src_b==0 -> DONE at E1.
//   MUL/DIVU otherwise -> BUSY, counter=WIDTH; one iteration per cycle; counter==1 -> DONE.
//   DONE is reached at E(WIDTH+1). Exec high-time: 2 cycles (ALU/div-by-0), WIDTH+2 cycles (MUL/DIVU).
//  DONE: instdone=1; results stable. exec=0 -> IDLE. exec=1 -> stay in DONE with instdone held.
//   The controller leaves Exec one cycle after DONE. A new start therefore requires exec low then high again.
//  ADD/SUB: result_lo = (a +/- b) mod 2^WIDTH; carry/borrow is discarded; result_hi=0.
//  MUL: shift-add on a 2W accumulator; result = exact {hi,lo} = a*b.
//  DIVU: restoring divide; quotient -> result_lo, remainder -> result_hi.
//   Divide by zero: result_lo = all ones, result_hi = src_a, div_by_zero=1.
//  Results hold from DONE until the next start, covering the Mem and WB stages.
//  Abort: exec falls while BUSY -> IDLE; proto_err=1; result_valid stays 0.
//  One-hot check: on every cycle after reset release, the count of the 5 strobes must be exactly 1.
//   Any other count sets proto_err. The check is masked in the first cycle after rst_n deasserts.
//  op/src changes during BUSY or DONE have no effect.
//  rst_n low at any time (mid-iteration included) -> immediate return to the reset values.
// STRUCTURE
//  Package exec_unit_pkg: op codes (OP_ADD/OP_SUB/OP_MUL/OP_DIVU), state encoding, strobe index constants.
//  Sub-module iter_muldiv: WIDTH-parameterised shift-add/restoring-divide datapath.
//   Interface: load, mode, step, a, b -> hi, lo.
//   Top level holds the FSM, counter, one-hot checker and ALU ops.
// TESTING (WIDTH=8; controller model holds exec until instdone)
//  ADD 0xF0+0x20 -> instdone at E1, result_lo=0x10, result_hi=0x00, exec high exactly 2 cycles.
//  SUB 5-9 -> result_lo=0xFC, result_hi=0; MUL 200*200 -> instdone at E9, hi=0x9C, lo=0x40.
//  DIVU 100/7 -> lo=14, hi=2, instdone at E9; DIVU 37/0 -> E1, lo=0xFF, hi=37, div_by_zero=1.
//  Drop exec at E4 of a MUL -> IDLE next cycle, proto_err=1 and sticky, result_valid=0; next ADD still runs.
//  Force exec&mem both high one cycle -> proto_err=1; pulse rst_n low mid-DIVU -> all outputs 0 immediately.
//  Back-to-back: 3 instructions through the full 5-stage loop.
//   Each result is held through its Mem and WB stages; result_valid drops at each new E0.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the multicycle execution unit: op codes, FSM
// state encoding and the bit positions of the stage strobes.
package exec_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  localparam int STB_IFETCH  = 0;
  localparam int STB_IDECODE = 1;
  localparam int STB_EXEC    = 2;
  localparam int STB_MEM     = 3;
  localparam int STB_WB      = 4;
  localparam int NUM_STB     = 5;

  function automatic logic [2:0] count_ones5(input logic [NUM_STB-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_STB; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative datapath: shift-add unsigned multiply (mode 0) or restoring
// unsigned divide (mode 1), one bit per step over a {hi,lo} register pair.
module iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_tmp;
  logic [WIDTH:0]   div_diff;

  // lo holds the multiplier (shifted out LSB first) or the dividend/quotient
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    mode_d   = mode_q;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_tmp  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_tmp - {1'b0, b_q};
    if (load) begin
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
      mode_d = mode;
    end else if (step) begin
      if (!mode_q) begin
        {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_tmp[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      mode_q <= mode_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/multicycle_exec_unit.sv
// Exec-stage responder: runs ADD/SUB/MUL/DIVU while exec is held, raises
// instdone to release the stage controller, and checks strobe one-hotness.
module multicycle_exec_unit
  import exec_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifetch,
  input  logic             idecode,
  input  logic             exec,
  input  logic             mem,
  input  logic             wb,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             instdone,
  output logic             busy,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             result_valid,
  output logic             div_by_zero,
  output logic             proto_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             chk_en_q;
  logic             proto_err_q, proto_err_d;
  logic             result_valid_q, result_valid_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             use_md_q, use_md_d;
  logic [WIDTH-1:0] alu_lo_q, alu_lo_d;
  logic [WIDTH-1:0] alu_hi_q, alu_hi_d;

  logic [NUM_STB-1:0] strobes;
  logic               md_load;
  logic               md_step;
  logic [WIDTH-1:0]   md_hi;
  logic [WIDTH-1:0]   md_lo;

  always_comb begin
    strobes              = '0;
    strobes[STB_IFETCH]  = ifetch;
    strobes[STB_IDECODE] = idecode;
    strobes[STB_EXEC]    = exec;
    strobes[STB_MEM]     = mem;
    strobes[STB_WB]      = wb;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    proto_err_d    = proto_err_q;
    result_valid_d = result_valid_q;
    div_by_zero_d  = div_by_zero_q;
    use_md_d       = use_md_q;
    alu_lo_d       = alu_lo_q;
    alu_hi_d       = alu_hi_q;
    md_load        = 1'b0;
    md_step        = 1'b0;

    if (chk_en_q && (count_ones5(strobes) != 3'd1)) begin
      proto_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (exec) begin
          result_valid_d = 1'b0;
          div_by_zero_d  = 1'b0;
          use_md_d       = 1'b0;
          alu_hi_d       = '0;
          unique case (op)
            OP_ADD: begin
              alu_lo_d       = src_a + src_b;
              result_valid_d = 1'b1;
              state_d        = ST_DONE;
            end
            OP_SUB: begin
              alu_lo_d       = src_a - src_b;
              result_valid_d = 1'b1;
              state_d        = ST_DONE;
            end
            OP_MUL: begin
              md_load  = 1'b1;
              use_md_d = 1'b1;
              cnt_d    = CW'(WIDTH);
              state_d  = ST_BUSY;
            end
            default: begin
              // Divide by zero bypasses the iterator with a fixed result
              if (src_b == '0) begin
                alu_lo_d       = '1;
                alu_hi_d       = src_a;
                div_by_zero_d  = 1'b1;
                result_valid_d = 1'b1;
                state_d        = ST_DONE;
              end else begin
                md_load  = 1'b1;
                use_md_d = 1'b1;
                cnt_d    = CW'(WIDTH);
                state_d  = ST_BUSY;
              end
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (!exec) begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          md_step = 1'b1;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!exec) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      chk_en_q       <= 1'b0;
      proto_err_q    <= 1'b0;
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
      use_md_q       <= 1'b0;
      alu_lo_q       <= '0;
      alu_hi_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      chk_en_q       <= 1'b1;
      proto_err_q    <= proto_err_d;
      result_valid_q <= result_valid_d;
      div_by_zero_q  <= div_by_zero_d;
      use_md_q       <= use_md_d;
      alu_lo_q       <= alu_lo_d;
      alu_hi_q       <= alu_hi_d;
    end
  end

  iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk  (clk),
    .rst_n(rst_n),
    .load (md_load),
    .mode (op == OP_DIVU),
    .step (md_step),
    .a    (src_a),
    .b    (src_b),
    .hi   (md_hi),
    .lo   (md_lo)
  );

  assign instdone     = (state_q == ST_DONE);
  assign busy         = (state_q == ST_BUSY);
  assign result_lo    = use_md_q ? md_lo : alu_lo_q;
  assign result_hi    = use_md_q ? md_hi : alu_hi_q;
  assign result_valid = result_valid_q;
  assign div_by_zero  = div_by_zero_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// Bench for multicycle_exec_unit: a stage-controller model drives the 5-stage
// loop while an arithmetic reference model supplies expected results/latency.
module tb_multicycle_exec_unit;

  localparam int WIDTH = 8;
  localparam int S_NONE = -1, S_IFETCH = 0, S_IDECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ifetch = 1'b0, idecode = 1'b0, exec = 1'b0, mem = 1'b0, wb = 1'b0;
  logic [1:0]       op = '0;
  logic [WIDTH-1:0] src_a = '0, src_b = '0;
  logic             instdone, busy, result_valid, div_by_zero, proto_err;
  logic [WIDTH-1:0] result_lo, result_hi;

  int   tests = 0;
  int   fails = 0;
  logic [7:0] prev_lo = '0, prev_hi = '0;
  logic prev_valid = 1'b0;
  bit   prev_known = 1'b0;
  logic exp_perr = 1'b0;

  multicycle_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ifetch      (ifetch),
    .idecode     (idecode),
    .exec        (exec),
    .mem         (mem),
    .wb          (wb),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .instdone    (instdone),
    .busy        (busy),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .result_valid(result_valid),
    .div_by_zero (div_by_zero),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stage(input int s);
    ifetch  = (s == S_IFETCH);
    idecode = (s == S_IDECODE);
    exec    = (s == S_EXEC);
    mem     = (s == S_MEM);
    wb      = (s == S_WB);
  endtask

  // Reference: plain integer arithmetic plus the documented completion latency
  task automatic model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] lo, output logic [7:0] hi,
                       output logic dbz, output int lat);
    int ai, bi, p;
    ai = a; bi = b;
    dbz = 1'b0; lat = 1; hi = 8'd0;
    case (o)
      2'd0: lo = 8'((ai + bi) & 255);
      2'd1: lo = 8'((ai - bi) & 255);
      2'd2: begin p = ai * bi; lo = 8'(p & 255); hi = 8'(p / 256); lat = WIDTH + 1; end
      default: begin
        if (bi == 0) begin lo = 8'hFF; hi = a; dbz = 1'b1; end
        else begin lo = 8'(ai / bi); hi = 8'(ai % bi); lat = WIDTH + 1; end
      end
    endcase
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".instdone"}, instdone, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".lo"}, result_lo, 0);
    check({tag, ".hi"}, result_hi, 0);
    check({tag, ".valid"}, result_valid, 0);
    check({tag, ".dbz"}, div_by_zero, 0);
    check({tag, ".perr"}, proto_err, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    set_stage(S_NONE);
    #1 check_zero(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_stage(S_IFETCH);
    @(negedge clk);
    check({tag, ".mask_perr"}, proto_err, 0);
    prev_lo = '0; prev_hi = '0; prev_valid = 1'b0; prev_known = 1'b1; exp_perr = 1'b0;
  endtask

  task automatic apply_stimulus(input string tag, input logic [1:0] o, input logic [7:0] a,
                                input logic [7:0] b, input bit scramble);
    logic [7:0] e_lo, e_hi;
    logic       e_dbz;
    int         lat, n;
    bit         seen;
    model(o, a, b, e_lo, e_hi, e_dbz, lat);
    @(negedge clk);
    set_stage(S_IFETCH);
    if (prev_known) begin
      check({tag, ".hold_if_lo"}, result_lo, prev_lo);
      check({tag, ".hold_if_hi"}, result_hi, prev_hi);
      check({tag, ".hold_if_valid"}, result_valid, prev_valid);
    end
    @(negedge clk);
    set_stage(S_IDECODE);
    @(negedge clk);
    set_stage(S_EXEC);
    op = o; src_a = a; src_b = b;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (scramble) {op, src_a, src_b} = 18'($urandom);
      if (n == 1 && lat > 1) begin
        check({tag, ".e1_busy"}, busy, 1);
        check({tag, ".e1_valid"}, result_valid, 0);
      end
      if (instdone) seen = 1;
    end
    check({tag, ".latency"}, n, lat);
    check({tag, ".lo"}, result_lo, e_lo);
    check({tag, ".hi"}, result_hi, e_hi);
    check({tag, ".valid"}, result_valid, 1);
    check({tag, ".dbz"}, div_by_zero, e_dbz);
    check({tag, ".perr"}, proto_err, exp_perr);
    @(negedge clk);
    set_stage(S_MEM);
    check({tag, ".mem_instdone"}, instdone, 1);
    check({tag, ".mem_lo"}, result_lo, e_lo);
    @(negedge clk);
    set_stage(S_WB);
    check({tag, ".wb_instdone"}, instdone, 0);
    check({tag, ".wb_lo"}, result_lo, e_lo);
    check({tag, ".wb_hi"}, result_hi, e_hi);
    check({tag, ".wb_valid"}, result_valid, 1);
    prev_lo = e_lo; prev_hi = e_hi; prev_valid = 1'b1; prev_known = 1'b1;
  endtask

  initial begin
    do_reset("reset");

    apply_stimulus("add", 2'd0, 8'hF0, 8'h20, 1'b0);
    apply_stimulus("sub", 2'd1, 8'd5, 8'd9, 1'b0);
    apply_stimulus("mul", 2'd2, 8'd200, 8'd200, 1'b1);
    apply_stimulus("divu", 2'd3, 8'd100, 8'd7, 1'b1);
    apply_stimulus("div0", 2'd3, 8'd37, 8'd0, 1'b1);

    // MUL aborted by exec falling in E4
    @(negedge clk); set_stage(S_IFETCH);
    @(negedge clk); set_stage(S_IDECODE);
    @(negedge clk); set_stage(S_EXEC);
    op = 2'd2; src_a = 8'd200; src_b = 8'd200;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("abort.busy_before", busy, 1);
    set_stage(S_IFETCH);
    @(negedge clk);
    check("abort.busy", busy, 0);
    check("abort.instdone", instdone, 0);
    check("abort.perr", proto_err, 1);
    check("abort.valid", result_valid, 0);
    @(negedge clk);
    check("abort.perr_sticky", proto_err, 1);
    prev_known = 1'b0;
    exp_perr = 1'b1;
    apply_stimulus("add_after_abort", 2'd0, 8'd3, 8'd4, 1'b0);

    @(negedge clk);
    do_reset("reset2");

    // exec and mem both high for one cycle
    @(negedge clk);
    set_stage(S_EXEC); mem = 1'b1;
    op = 2'd0; src_a = 8'd1; src_b = 8'd2;
    @(negedge clk);
    set_stage(S_MEM);
    check("twohot.perr", proto_err, 1);
    check("twohot.instdone", instdone, 1);
    check("twohot.lo", result_lo, 3);
    @(negedge clk);
    set_stage(S_WB);
    check("twohot.perr_sticky", proto_err, 1);
    check("twohot.idle", instdone, 0);

    // Reset pulse in the middle of a divide
    @(negedge clk); set_stage(S_IFETCH);
    @(negedge clk); set_stage(S_IDECODE);
    @(negedge clk); set_stage(S_EXEC);
    op = 2'd3; src_a = 8'd100; src_b = 8'd7;
    repeat (3) @(negedge clk);
    check("middiv.busy", busy, 1);
    do_reset("middiv_rst");

    for (int i = 0; i < 25; i++) begin
      logic [1:0] ro;
      logic [7:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      apply_stimulus($sformatf("rand%0d", i), ro, ra, rb, 1'b1);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
